// File: rtl/uart_host_nic_ctrl_pkg.sv
`default_nettype none
//==============================================================================
// Module      : uart_host_pkg
// Description : Shared types and defaults for the UART NIC host controller:
//               FSM state encoding, arbiter grant encoding, default widths.
// Revision    : 1.0 - initial release
//==============================================================================
package uart_host_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 4;

  // Access FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_CAP  = 2'd3
  } state_e;

  // Encoding of the arbiter's last-grant memory
  typedef enum logic {
    GNT_TX = 1'b0,
    GNT_RX = 1'b1
  } grant_e;

  // Bit positions in the arbiter request/grant vectors
  localparam int REQ_TX = 0;
  localparam int REQ_RX = 1;

endpackage
`default_nettype wire

// File: rtl/uart_host_nic_ctrl_if.sv
`default_nettype none
//==============================================================================
// Module      : uart_host_nic_ctrl_if
// Description : NIC access port bundle. The host controller is the master
//               (drives strobes and write data); the NIC is the slave.
// Revision    : 1.0 - initial release
//==============================================================================
interface uart_host_nic_ctrl_if #(
  parameter int DATA_W = uart_host_pkg::DEF_DATA_W
);
  logic              nic_wr_en;
  logic [DATA_W-1:0] nic_wr_data;
  logic              nic_rd_en;
  logic [DATA_W-1:0] nic_rd_data;
  logic              nic_rx_valid;
  logic              nic_tx_full;

  modport master (
    output nic_wr_en, nic_wr_data, nic_rd_en,
    input  nic_rd_data, nic_rx_valid, nic_tx_full
  );

  modport slave (
    input  nic_wr_en, nic_wr_data, nic_rd_en,
    output nic_rd_data, nic_rx_valid, nic_tx_full
  );
endinterface
`default_nettype wire

// File: rtl/uart_host_nic_ctrl_rr_arb2.sv
`default_nettype none
//==============================================================================
// Module      : uart_host_rr_arb2
// Description : Two-requester round-robin arbiter. On a tie the requester not
//               granted last wins; a lone requester always wins. The memory
//               of the last grant only moves when enabled and something wins.
// Revision    : 1.0 - initial release
//==============================================================================
module uart_host_rr_arb2
  import uart_host_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  grant_e last_q;

  // One-hot grant; TX wins a tie when RX was served last
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i[REQ_TX] && req_i[REQ_RX]) begin
        gnt_o[REQ_TX] = (last_q == GNT_RX);
        gnt_o[REQ_RX] = (last_q == GNT_TX);
      end else begin
        gnt_o = req_i;
      end
    end
  end

  // Remember the winner; reset to RX so the first tie goes to TX
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= GNT_RX;
    end else if (|gnt_o) begin
      last_q <= gnt_o[REQ_RX] ? GNT_RX : GNT_TX;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_host_nic_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : uart_host_nic_ctrl
// Description : Host-side NIC access controller. Converts the send button and
//               the NIC receive flag into single-cycle write/read strobes,
//               round-robin shares the NIC port, captures received bytes for
//               the display and counts traffic.
//               Build option: define UART_HOST_CNT_SAT_EN to make the byte
//               counters saturate instead of wrapping.
// Revision    : 1.0 - initial release
//==============================================================================
module uart_host_nic_ctrl
  import uart_host_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send_btn,
  input  logic [DATA_W-1:0] send_data,
  uart_host_nic_ctrl_if.master nic,
  output logic [DATA_W-1:0] disp_data,
  output logic [CNT_W-1:0]  rx_count,
  output logic [CNT_W-1:0]  tx_count,
  output logic              tx_drop
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_WR   = ST_WR;
  localparam logic [1:0] S_RD   = ST_RD;
  localparam logic [1:0] S_CAP  = ST_CAP;

  logic [1:0]        state_q, state_d;
  logic              send_btn_q;
  logic              tx_pend_q;
  logic [DATA_W-1:0] tx_hold_q;
  logic              tx_drop_q;
  logic              wr_en_q, rd_en_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W-1:0] disp_q;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [1:0]        gnt;
  logic              press, in_idle, in_wr, in_cap;

  assign press   = send_btn & ~send_btn_q;
  assign in_idle = (state_q == S_IDLE);
  assign in_wr   = (state_q == S_WR);
  assign in_cap  = (state_q == S_CAP);

  uart_host_rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en_i  (in_idle),
    .req_i ({nic.nic_rx_valid, tx_pend_q & ~nic.nic_tx_full}),
    .gnt_o (gnt)
  );

`ifdef UART_HOST_CNT_SAT_EN
  assign tx_cnt_d = (&tx_cnt_q) ? tx_cnt_q : tx_cnt_q + CNT_W'(1);
  assign rx_cnt_d = (&rx_cnt_q) ? rx_cnt_q : rx_cnt_q + CNT_W'(1);
`else
  assign tx_cnt_d = tx_cnt_q + CNT_W'(1);
  assign rx_cnt_d = rx_cnt_q + CNT_W'(1);
`endif

  // Next state: grants only leave IDLE; every access returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (gnt[REQ_TX])      state_d = S_WR;
        else if (gnt[REQ_RX]) state_d = S_RD;
      end
      S_WR:    state_d = S_IDLE;
      S_RD:    state_d = S_CAP;
      S_CAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Edge detect and single-entry TX holding register; a press landing in
  // the WR cycle refills the slot instead of being dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      send_btn_q <= 1'b0;
      tx_pend_q  <= 1'b0;
      tx_hold_q  <= '0;
      tx_drop_q  <= 1'b0;
    end else begin
      send_btn_q <= send_btn;
      tx_drop_q  <= press & tx_pend_q & ~in_wr;
      if (press && (!tx_pend_q || in_wr)) begin
        tx_pend_q <= 1'b1;
        tx_hold_q <= send_data;
      end else if (in_wr) begin
        tx_pend_q <= 1'b0;
      end
    end
  end

  // FSM and registered strobes, set at grant so they line up with WR/RD
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      wr_en_q <= gnt[REQ_TX];
      rd_en_q <= gnt[REQ_RX];
      if (gnt[REQ_TX]) wr_data_q <= tx_hold_q;
    end
  end

  // Capture read data in CAP and count completed accesses
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q   <= '0;
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (in_cap) begin
        disp_q   <= nic.nic_rd_data;
        rx_cnt_q <= rx_cnt_d;
      end
      if (in_wr) tx_cnt_q <= tx_cnt_d;
    end
  end

  assign nic.nic_wr_en   = wr_en_q;
  assign nic.nic_wr_data = wr_data_q;
  assign nic.nic_rd_en   = rd_en_q;
  assign disp_data       = disp_q;
  assign rx_count        = rx_cnt_q;
  assign tx_count        = tx_cnt_q;
  assign tx_drop         = tx_drop_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_host_nic_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : tb_uart_host_nic_ctrl
// Description : Directed self-checking bench for uart_host_nic_ctrl.
//               Expectations follow UART_HOST_CNT_SAT_EN when defined.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_uart_host_nic_ctrl;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          send_btn;
  logic [DW-1:0] send_data;
  logic [DW-1:0] disp_data;
  logic [CW-1:0] rx_count;
  logic [CW-1:0] tx_count;
  logic          tx_drop;

  int vectors     = 0;
  int miscompares = 0;

  uart_host_nic_ctrl_if #(.DATA_W(DW)) nic_if ();

  uart_host_nic_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .send_btn  (send_btn),
    .send_data (send_data),
    .nic       (nic_if),
    .disp_data (disp_data),
    .rx_count  (rx_count),
    .tx_count  (tx_count),
    .tx_drop   (tx_drop)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst                 = 1'b1;
    send_btn            = 1'b0;
    send_data           = '0;
    nic_if.nic_rx_valid = 1'b0;
    nic_if.nic_tx_full  = 1'b0;
    nic_if.nic_rd_data  = '0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (nic_if.nic_wr_en !== 1'b0 || nic_if.nic_rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_strobes: wr_en=%b rd_en=%b, expected 0 0", nic_if.nic_wr_en, nic_if.nic_rd_en);
    end
    vectors++;
    if (nic_if.nic_wr_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_wr_data: got %h, expected 00", nic_if.nic_wr_data);
    end
    vectors++;
    if (disp_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_disp: got %h, expected 00", disp_data);
    end
    vectors++;
    if (rx_count !== 4'd0 || tx_count !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_counts: rx=%0d tx=%0d, expected 0 0", rx_count, tx_count);
    end
    vectors++;
    if (tx_drop !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_drop: got %b, expected 0", tx_drop);
    end
  endtask

  task automatic test_single_write();
    int strobes = 0;
    send_data = 8'h5A;
    send_btn  = 1'b1;                       // cycle N
    step();                                 // N+1
    send_btn = 1'b0;
    vectors++;
    if (nic_if.nic_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL write_early: wr_en=%b at N+1, expected 0", nic_if.nic_wr_en);
    end
    step();                                 // N+2
    vectors++;
    if (nic_if.nic_wr_en !== 1'b1 || nic_if.nic_wr_data !== 8'h5A) begin
      miscompares++;
      $display("FAIL write_strobe: wr_en=%b data=%h at N+2, expected 1 5a", nic_if.nic_wr_en, nic_if.nic_wr_data);
    end
    step();                                 // N+3
    vectors++;
    if (nic_if.nic_wr_en !== 1'b0 || tx_count !== 4'd1) begin
      miscompares++;
      $display("FAIL write_after: wr_en=%b tx_count=%0d, expected 0 1", nic_if.nic_wr_en, tx_count);
    end
    repeat (8) begin
      step();
      if (nic_if.nic_wr_en !== 1'b0 || nic_if.nic_rd_en !== 1'b0) strobes++;
    end
    vectors++;
    if (strobes !== 0) begin
      miscompares++;
      $display("FAIL write_quiet: %0d extra strobe cycles, expected 0", strobes);
    end
  endtask

  task automatic test_rx_burst();
    logic [7:0] bytes [3] = '{8'h11, 8'h22, 8'h33};
    logic [7:0] exp_disp = 8'h00;
    int k = 0, last = -10, first = -1, bad = 0, cap_chk = -1;
    nic_if.nic_rx_valid = 1'b1;             // cycle M (index 0)
    for (int c = 1; c <= 20; c++) begin
      step();
      if (cap_chk == c) begin
        vectors++;
        if (disp_data !== exp_disp) begin
          miscompares++;
          $display("FAIL rx_disp_latency: got %h at read+2, expected %h", disp_data, exp_disp);
        end
      end
      if (nic_if.nic_rd_en === 1'b1) begin
        if (first < 0) first = c;
        if (c - last < 3) bad++;
        last = c;
        if (k < 3) begin
          nic_if.nic_rd_data = bytes[k];
          exp_disp = bytes[k];
          cap_chk = c + 2;
        end
        k++;
        if (k == 3) nic_if.nic_rx_valid = 1'b0;
      end
      if (nic_if.nic_wr_en !== 1'b0) bad++;
    end
    vectors++;
    if (first !== 1) begin
      miscompares++;
      $display("FAIL rx_first_latency: first rd_en at M+%0d, expected M+1", first);
    end
    vectors++;
    if (k !== 3 || bad !== 0) begin
      miscompares++;
      $display("FAIL rx_strobes: reads=%0d spacing_errs=%0d, expected 3 0", k, bad);
    end
    vectors++;
    if (disp_data !== 8'h33 || rx_count !== 4'd3) begin
      miscompares++;
      $display("FAIL rx_final: disp=%h rx_count=%0d, expected 33 3", disp_data, rx_count);
    end
  endtask

  // TX and RX become eligible in the same cycle, and keep colliding
  task automatic test_tie_alternation();
    logic [7:0] wq [$];
    logic [7:0] exp_w;
    logic [5:0] seq = '0;
    int n = 0, presses = 1, reads = 0, bad = 0, first_w = -1;
    logic prev = 1'b0;
    do_reset();
    send_data = 8'hA0;
    send_btn  = 1'b1;                       // cycle 0
    wq.push_back(8'hA0);
    for (int c = 1; c <= 40; c++) begin
      step();
      send_btn = 1'b0;
      // rx_valid rises the cycle tx_pend becomes visible: a true tie
      if (c == 1) nic_if.nic_rx_valid = 1'b1;
      if (nic_if.nic_wr_en === 1'b1 && nic_if.nic_rd_en === 1'b1) bad++;
      if (prev && (nic_if.nic_wr_en === 1'b1 || nic_if.nic_rd_en === 1'b1)) bad++;
      if (tx_drop !== 1'b0) bad++;
      prev = (nic_if.nic_wr_en === 1'b1) || (nic_if.nic_rd_en === 1'b1);
      if (nic_if.nic_wr_en === 1'b1) begin
        if (first_w < 0) first_w = c;
        if (n < 6) n++;
        exp_w = (wq.size() > 0) ? wq.pop_front() : 8'hxx;
        vectors++;
        if (nic_if.nic_wr_data !== exp_w) begin
          miscompares++;
          $display("FAIL tie_wr_data: got %h, expected %h", nic_if.nic_wr_data, exp_w);
        end
        if (presses < 3) begin
          send_data = 8'hA0 + 8'(presses);
          wq.push_back(send_data);
          send_btn = 1'b1;
          presses++;
        end
      end
      if (nic_if.nic_rd_en === 1'b1) begin
        if (n < 6) begin
          seq[n] = 1'b1;
          n++;
        end
        nic_if.nic_rd_data = 8'hB0 + 8'(reads);
        reads++;
        if (reads == 3) nic_if.nic_rx_valid = 1'b0;
      end
    end
    vectors++;
    if (first_w !== 2) begin
      miscompares++;
      $display("FAIL tie_first_tx: first write at cycle %0d, expected 2", first_w);
    end
    vectors++;
    if (n !== 6 || seq !== 6'b101010) begin
      miscompares++;
      $display("FAIL tie_order: n=%0d seq=%b (bit=1 read), expected 6 101010", n, seq);
    end
    vectors++;
    if (bad !== 0 || tx_count !== 4'd3 || rx_count !== 4'd3) begin
      miscompares++;
      $display("FAIL tie_rules: errs=%0d tx=%0d rx=%0d, expected 0 3 3", bad, tx_count, rx_count);
    end
  endtask

  task automatic test_full_drop();
    int drops = 0, drop_at = -1, writes = 0, wr_at = -1;
    logic [7:0] wdata = 8'h00;
    nic_if.nic_tx_full = 1'b1;
    send_data = 8'h3C;
    send_btn  = 1'b1;                       // cycle 0
    for (int c = 1; c <= 20; c++) begin
      step();
      send_btn = 1'b0;
      if (c == 5) begin
        send_data = 8'hFF;
        send_btn  = 1'b1;
      end
      if (c == 12) nic_if.nic_tx_full = 1'b0;
      if (tx_drop === 1'b1) begin
        drops++;
        drop_at = c;
      end
      if (nic_if.nic_wr_en === 1'b1) begin
        writes++;
        wr_at = c;
        wdata = nic_if.nic_wr_data;
      end
    end
    vectors++;
    if (drops !== 1 || drop_at !== 6) begin
      miscompares++;
      $display("FAIL full_drop: pulses=%0d at %0d, expected 1 at 6", drops, drop_at);
    end
    vectors++;
    if (writes !== 1 || wr_at !== 13) begin
      miscompares++;
      $display("FAIL full_write: writes=%0d at %0d, expected 1 at 13", writes, wr_at);
    end
    vectors++;
    if (wdata !== 8'h3C) begin
      miscompares++;
      $display("FAIL full_data: got %h, expected 3c", wdata);
    end
  endtask

  task automatic test_reset_during_rd();
    int found = 0;
    nic_if.nic_rd_data  = 8'h77;
    nic_if.nic_rx_valid = 1'b1;
    for (int c = 0; c < 10 && found == 0; c++) begin
      step();
      if (nic_if.nic_rd_en === 1'b1) found = 1;
    end
    vectors++;
    if (found !== 1) begin
      miscompares++;
      $display("FAIL rstrd_timeout: no rd_en within 10 cycles, expected one");
    end
    rst = 1'b1;                             // sampled at the end of RD
    step();
    rst = 1'b0;
    nic_if.nic_rd_data = 8'h5C;
    vectors++;
    if (disp_data !== 8'h00 || rx_count !== 4'd0 || tx_count !== 4'd0) begin
      miscompares++;
      $display("FAIL rstrd_state: disp=%h rx=%0d tx=%0d, expected 00 0 0", disp_data, rx_count, tx_count);
    end
    step();
    vectors++;
    if (nic_if.nic_rd_en !== 1'b1) begin
      miscompares++;
      $display("FAIL rstrd_reread: rd_en=%b one cycle after reset release, expected 1", nic_if.nic_rd_en);
    end
    nic_if.nic_rx_valid = 1'b0;
    step();
    vectors++;
    if (disp_data !== 8'h00 || rx_count !== 4'd0) begin
      miscompares++;
      $display("FAIL rstrd_nocap: disp=%h rx=%0d during CAP, expected 00 0", disp_data, rx_count);
    end
    step();
    vectors++;
    if (disp_data !== 8'h5C || rx_count !== 4'd1) begin
      miscompares++;
      $display("FAIL rstrd_capture: disp=%h rx=%0d, expected 5c 1", disp_data, rx_count);
    end
  endtask

  task automatic test_count_wrap();
    int reads = 0;
    logic [3:0] exp_cnt;
`ifdef UART_HOST_CNT_SAT_EN
    exp_cnt = 4'd15;
`else
    exp_cnt = 4'd1;
`endif
    do_reset();
    nic_if.nic_rx_valid = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      step();
      if (nic_if.nic_rd_en === 1'b1) begin
        reads++;
        nic_if.nic_rd_data = 8'(c);
        if (reads == 17) nic_if.nic_rx_valid = 1'b0;
      end
    end
    vectors++;
    if (reads !== 17) begin
      miscompares++;
      $display("FAIL wrap_reads: got %0d reads, expected 17", reads);
    end
    vectors++;
    if (rx_count !== exp_cnt) begin
      miscompares++;
      $display("FAIL wrap_count: rx_count=%0d, expected %0d", rx_count, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_rx_burst();
    test_tie_alternation();
    test_full_drop();
    test_reset_during_rd();
    test_count_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_host_nic_ctrl.md
# uart_host_nic_ctrl

Host-side access controller for the UART NIC. It turns the raw send button and the NIC's receive-ready flag into single-cycle NIC write and read strobes. It shares the single NIC access port between the transmit path (button data) and the receive path (display data) with round-robin arbitration. It captures received bytes for the 7-segment display and counts them for the LEDs, and sits between board I/O and the NIC, replacing ad-hoc strobe logic.

## Interface
- DATA_W, 8, NIC data width
- CNT_W, 4, width of the rx/tx byte counters

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- send_btn  in  1  send request level, already synchronized to clk
- send_data  in  DATA_W  switch data, sampled on send_btn rising edge
- nic_rx_valid  in  1  NIC holds at least one unread byte
- nic_tx_full  in  1  NIC cannot accept a write this cycle
- nic_rd_data  in  DATA_W  NIC read data, valid the cycle after nic_rd_en
- nic_wr_en  out  1  one-cycle write strobe
- nic_wr_data  out  DATA_W  write data, valid while nic_wr_en=1
- nic_rd_en  out  1  one-cycle read strobe
- disp_data  out  DATA_W  last received byte, to the binary-to-7seg decoder
- rx_count  out  CNT_W  bytes received since reset
- tx_count  out  CNT_W  bytes written since reset
- tx_drop  out  1  one-cycle pulse: press lost because a transmit was already pending

## Operation
- Edge detect: press = send_btn & ~send_btn_q. On press with no pending TX: tx_pend←1, tx_hold←send_data. On press with tx_pend=1: tx_hold is unchanged and tx_drop pulses the next cycle.
- TX eligible = tx_pend & ~nic_tx_full. RX eligible = nic_rx_valid.
- FSM states: IDLE, WR, RD, CAP.
  - IDLE→WR when TX is granted. IDLE→RD when RX is granted. Otherwise IDLE.
  - WR→IDLE. In the cycle it is in WR, the block drives nic_wr_en=1, nic_wr_data=tx_hold, clears tx_pend, and increments tx_count.
  - RD→CAP. In the cycle it is in RD, the block drives nic_rd_en=1.
  - CAP→IDLE. In the cycle it is in CAP, disp_data←nic_rd_data and rx_count increments.
- Arbitration happens only in IDLE.
  - If both requesters are eligible, the one not granted last wins. The last_grant bit updates on every grant; its reset value makes TX win the first tie.
  - If only one is eligible, it wins regardless of last_grant.
- A press in the same cycle that WR clears tx_pend is accepted as a new pending request, not dropped.
- Counters wrap modulo 2^CNT_W by default (see Configuration).
- nic_tx_full rising while tx_pend is set: the request stays pending and is not dropped.

## Timing
- Reset values: nic_wr_en=0, nic_rd_en=0, nic_wr_data=0, disp_data=0, rx_count=0, tx_count=0, tx_drop=0, state=IDLE, tx_pend=0, last_grant=RX.
- Reset mid-operation: any pending TX or in-flight read is abandoned. CAP does not occur and disp_data returns to 0.
- Press latency: send_btn first high at cycle N, with the bus idle and TX eligible:
  - tx_pend=1 at N+1
  - nic_wr_en=1 for exactly cycle N+2
- Read latency: nic_rx_valid high at cycle M, bus idle, RX granted:
  - nic_rd_en=1 at M+1
  - disp_data/rx_count update visible at M+3
- Strobes are single-cycle, mutually exclusive, and never asserted in consecutive cycles. The minimum spacing between NIC accesses is one idle cycle.
- All outputs are registered.

## Configuration
- UART_HOST_CNT_SAT_EN defined: rx_count and tx_count saturate at 2^CNT_W−1 and hold there until reset.
- UART_HOST_CNT_SAT_EN undefined: both counters wrap to 0 after 2^CNT_W−1.

## Structure
- Package uart_host_pkg holds:
  - the state enum (IDLE, WR, RD, CAP)
  - the grant encoding (GNT_TX, GNT_RX)
  - defaults for DATA_W and CNT_W
- Sub-module uart_host_rr_arb2: two-requester round-robin arbiter with the last_grant register and an enable input (asserted only in IDLE). Outputs a one-hot grant.

## Test plan
- Reset, then one press with send_data=0x5A, nic_tx_full=0, nic_rx_valid=0 → nic_wr_en high exactly at N+2 with nic_wr_data=0x5A; tx_count=1; no further strobes.
- nic_rx_valid held high for 3 bytes, returning 0x11, 0x22, 0x33 → three nic_rd_en pulses at least 3 cycles apart; disp_data ends at 0x33; rx_count=3.
- Press and nic_rx_valid rise in the same cycle, repeated → grants alternate, TX first after reset; no consecutive strobes.
- Press while nic_tx_full=1, second press 5 cycles later with data 0xFF → tx_drop pulses once; after full clears, nic_wr_data equals the first byte, not 0xFF.
- Assert rst during RD → no CAP; disp_data=0; rx_count=0; next read behaves as after reset.
- 17 received bytes with CNT_W=4 → rx_count=1 without the macro, 15 with UART_HOST_CNT_SAT_EN.
